// File: rtl/game_controller_if.sv
// Handshake and display bundle between the blackjack controller and its neighbours.
//   deal/hit/stand : single-cycle button pulses into the controller
//   cardValid/cardValue/cardReq : req/valid card handshake with the card source
//   playerHand/dealerHand/gameState : registered values for the seven-segment stage
// master = controller side, slave = surrounding environment.
interface game_controller_if;
  logic       deal;
  logic       hit;
  logic       stand;
  logic       cardValid;
  logic [3:0] cardValue;
  logic       cardReq;
  logic [4:0] playerHand;
  logic [4:0] dealerHand;
  logic [3:0] gameState;

  modport master (
    input  deal, hit, stand, cardValid, cardValue,
    output cardReq, playerHand, dealerHand, gameState
  );

  modport slave (
    output deal, hit, stand, cardValid, cardValue,
    input  cardReq, playerHand, dealerHand, gameState
  );
endinterface

// File: rtl/game_controller.sv
// Blackjack round sequencer: deals P,D,P,D, runs the player turn and the dealer
// draw rule, and resolves win/lose/tie.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : game_controller_if.master (buttons in, card handshake, display outputs)
module game_controller #(
  parameter int unsigned DEALER_STAND = 17,
  parameter bit          HIT_SOFT17   = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  game_controller_if.master  bus
);

  localparam int unsigned HAND_W  = 5;
  localparam int unsigned STATE_W = 4;
  localparam int unsigned CNT_W   = 3;

  localparam logic [STATE_W-1:0] S_RESET       = 4'd0;
  localparam logic [STATE_W-1:0] S_DEAL_PLAYER = 4'd1;
  localparam logic [STATE_W-1:0] S_DEAL_DEALER = 4'd2;
  localparam logic [STATE_W-1:0] S_PLAYER_TURN = 4'd3;
  localparam logic [STATE_W-1:0] S_DEALER_TURN = 4'd4;
  localparam logic [STATE_W-1:0] S_COMPARE     = 4'd5;
  localparam logic [STATE_W-1:0] S_RESULT_WIN  = 4'd6;
  localparam logic [STATE_W-1:0] S_RESULT_LOSE = 4'd7;
  localparam logic [STATE_W-1:0] S_RESULT_TIE  = 4'd8;

  localparam logic [HAND_W-1:0] STAND_TOTAL = HAND_W'(DEALER_STAND);
  localparam logic [HAND_W-1:0] BLACKJACK   = 5'd21;

  // Hard sum with ace = 1, saturating at 31.
  function automatic logic [HAND_W-1:0] add_sat(input logic [HAND_W-1:0] hard,
                                                input logic [HAND_W-1:0] val);
    logic [HAND_W:0] sum;
    sum = (HAND_W+1)'(hard) + (HAND_W+1)'(val);
    return sum[HAND_W] ? 5'd31 : sum[HAND_W-1:0];
  endfunction

  function automatic logic is_soft(input logic [HAND_W-1:0] hard, input logic ace);
    return ace && (hard <= 5'd11);
  endfunction

  function automatic logic [HAND_W-1:0] best(input logic [HAND_W-1:0] hard, input logic ace);
    return is_soft(hard, ace) ? hard + 5'd10 : hard;
  endfunction

  logic [STATE_W-1:0] state_q, state_d;
  logic [HAND_W-1:0]  p_hard_q, p_hard_d, d_hard_q, d_hard_d;
  logic               p_ace_q, p_ace_d, d_ace_q, d_ace_d;
  logic [CNT_W-1:0]   deal_cnt_q, deal_cnt_d;
  logic               card_req_q, card_req_d;
  logic [HAND_W-1:0]  player_hand_q, player_hand_d;
  logic [HAND_W-1:0]  dealer_hand_q, dealer_hand_d;

  // Card normalisation: 0 and 11..15 count as 10.
  logic [HAND_W-1:0] card_val_c;
  logic              card_ace_c;
  logic              take_c;
  logic [HAND_W-1:0] p_hard_new_c, d_hard_new_c;
  logic              p_ace_new_c, d_ace_new_c;
  logic [HAND_W-1:0] p_best_new_c, d_best_new_c;
  logic              dealer_draw_c;
  logic              start_c;

  always_comb begin
    card_val_c   = ((bus.cardValue == 4'd0) || (bus.cardValue > 4'd10)) ? 5'd10
                                                                        : HAND_W'(bus.cardValue);
    card_ace_c   = (bus.cardValue == 4'd1);
    take_c       = card_req_q && bus.cardValid;
    p_hard_new_c = add_sat(p_hard_q, card_val_c);
    d_hard_new_c = add_sat(d_hard_q, card_val_c);
    p_ace_new_c  = p_ace_q | card_ace_c;
    d_ace_new_c  = d_ace_q | card_ace_c;
    p_best_new_c = best(p_hard_new_c, p_ace_new_c);
    d_best_new_c = best(d_hard_new_c, d_ace_new_c);
    // Dealer rule evaluated on the registered dealer total.
    dealer_draw_c = (dealer_hand_q < STAND_TOTAL) ||
                    (HIT_SOFT17 && (dealer_hand_q == STAND_TOTAL) && is_soft(d_hard_q, d_ace_q));
  end

  // Next-state and datapath update.
  always_comb begin
    state_d       = state_q;
    p_hard_d      = p_hard_q;
    d_hard_d      = d_hard_q;
    p_ace_d       = p_ace_q;
    d_ace_d       = d_ace_q;
    deal_cnt_d    = deal_cnt_q;
    card_req_d    = card_req_q;
    player_hand_d = player_hand_q;
    dealer_hand_d = dealer_hand_q;
    start_c       = 1'b0;

    // A consumed card always closes the handshake.
    if (take_c) card_req_d = 1'b0;

    case (state_q)
      S_RESET: begin
        if (bus.deal) start_c = 1'b1;
      end
      S_DEAL_PLAYER: begin
        if (take_c) begin
          p_hard_d      = p_hard_new_c;
          p_ace_d       = p_ace_new_c;
          player_hand_d = p_best_new_c;
          deal_cnt_d    = deal_cnt_q + 3'd1;
          state_d       = S_DEAL_DEALER;
        end else if (!card_req_q) begin
          card_req_d = 1'b1;
        end
      end
      S_DEAL_DEALER: begin
        if (take_c) begin
          d_hard_d      = d_hard_new_c;
          d_ace_d       = d_ace_new_c;
          dealer_hand_d = d_best_new_c;
          deal_cnt_d    = deal_cnt_q + 3'd1;
          if (deal_cnt_q == 3'd3) begin
            if (player_hand_q == BLACKJACK)
              state_d = (d_best_new_c == BLACKJACK) ? S_RESULT_TIE : S_RESULT_WIN;
            else
              state_d = S_PLAYER_TURN;
          end else begin
            state_d = S_DEAL_PLAYER;
          end
        end else if (!card_req_q) begin
          card_req_d = 1'b1;
        end
      end
      S_PLAYER_TURN: begin
        // Buttons are ignored while a card is outstanding; stand beats hit.
        if (card_req_q) begin
          if (take_c) begin
            p_hard_d      = p_hard_new_c;
            p_ace_d       = p_ace_new_c;
            player_hand_d = p_best_new_c;
            if (p_best_new_c > BLACKJACK)       state_d = S_RESULT_LOSE;
            else if (p_best_new_c == BLACKJACK) state_d = S_DEALER_TURN;
          end
        end else if (bus.stand) begin
          state_d = S_DEALER_TURN;
        end else if (bus.hit) begin
          card_req_d = 1'b1;
        end
      end
      S_DEALER_TURN: begin
        if (card_req_q) begin
          if (take_c) begin
            d_hard_d      = d_hard_new_c;
            d_ace_d       = d_ace_new_c;
            dealer_hand_d = d_best_new_c;
          end
        end else if (dealer_hand_q > BLACKJACK) begin
          state_d = S_RESULT_WIN;
        end else if (dealer_draw_c) begin
          card_req_d = 1'b1;
        end else begin
          state_d = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (player_hand_q > dealer_hand_q)      state_d = S_RESULT_WIN;
        else if (player_hand_q < dealer_hand_q) state_d = S_RESULT_LOSE;
        else                                    state_d = S_RESULT_TIE;
      end
      S_RESULT_WIN, S_RESULT_LOSE, S_RESULT_TIE: begin
        if (bus.deal) start_c = 1'b1;
      end
      default: begin
        state_d    = S_RESET;
        card_req_d = 1'b0;
      end
    endcase

    // New round: clear both hands and restart the deal sequence.
    if (start_c) begin
      p_hard_d      = '0;
      d_hard_d      = '0;
      p_ace_d       = 1'b0;
      d_ace_d       = 1'b0;
      deal_cnt_d    = '0;
      player_hand_d = '0;
      dealer_hand_d = '0;
      card_req_d    = 1'b0;
      state_d       = S_DEAL_PLAYER;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_RESET;
      p_hard_q      <= '0;
      d_hard_q      <= '0;
      p_ace_q       <= 1'b0;
      d_ace_q       <= 1'b0;
      deal_cnt_q    <= '0;
      card_req_q    <= 1'b0;
      player_hand_q <= '0;
      dealer_hand_q <= '0;
    end else begin
      state_q       <= state_d;
      p_hard_q      <= p_hard_d;
      d_hard_q      <= d_hard_d;
      p_ace_q       <= p_ace_d;
      d_ace_q       <= d_ace_d;
      deal_cnt_q    <= deal_cnt_d;
      card_req_q    <= card_req_d;
      player_hand_q <= player_hand_d;
      dealer_hand_q <= dealer_hand_d;
    end
  end

  assign bus.cardReq    = card_req_q;
  assign bus.playerHand = player_hand_q;
  assign bus.dealerHand = dealer_hand_q;
  assign bus.gameState  = state_q;

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller: two instances (HIT_SOFT17 = 0 and 1), each with
// its own card source fed from a per-instance deck.
module tb_game_controller;

  localparam int DECK_N = 4096;
  localparam int STAND  = 17;
  localparam bit [15:0] M_POST_DEAL = 16'h01C8;  // states 3,6,7,8
  localparam bit [15:0] M_RESULT    = 16'h01C0;  // states 6,7,8

  logic clk;
  logic reset;
  logic deal_s [2];
  logic hit_s  [2];
  logic stand_s[2];
  int   delay_s[2];
  int   deck   [2][DECK_N];

  int n_tests;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    game_controller_if u_if();
    logic       valid;
    logic [3:0] value;
    int         rd;
    int         viol;
    int         req_res;

    assign u_if.deal      = deal_s[g];
    assign u_if.hit       = hit_s[g];
    assign u_if.stand     = stand_s[g];
    assign u_if.cardValid = valid;
    assign u_if.cardValue = value;

    game_controller #(.DEALER_STAND(17), .HIT_SOFT17(1'(g))) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if)
    );

    // Card source: answers cardReq after delay_s cycles, pops one card per accept.
    initial begin : src
      int wait_cnt;
      wait_cnt = 0;
      valid    = 1'b0;
      value    = 4'd0;
      rd       = 0;
      viol     = 0;
      req_res  = 0;
      forever begin
        @(negedge clk);
        if (u_if.cardReq && (u_if.gameState >= 4'd6) && (u_if.gameState <= 4'd8)) req_res++;
        if (valid) begin
          // valid and req were both high at the last edge, so req must be low now
          if (u_if.cardReq) viol++;
          valid    = 1'b0;
          rd++;
          wait_cnt = 0;
        end else if (u_if.cardReq) begin
          if (wait_cnt >= delay_s[g]) begin
            valid = 1'b1;
            value = 4'(deck[g][rd % DECK_N]);
          end else begin
            wait_cnt++;
          end
        end else begin
          wait_cnt = 0;
        end
      end
    end
  end

  function automatic int st(input int sel);
    return (sel == 0) ? int'(g_dut[0].u_if.gameState) : int'(g_dut[1].u_if.gameState);
  endfunction
  function automatic int ph(input int sel);
    return (sel == 0) ? int'(g_dut[0].u_if.playerHand) : int'(g_dut[1].u_if.playerHand);
  endfunction
  function automatic int dh(input int sel);
    return (sel == 0) ? int'(g_dut[0].u_if.dealerHand) : int'(g_dut[1].u_if.dealerHand);
  endfunction
  function automatic int rq(input int sel);
    return (sel == 0) ? int'(g_dut[0].u_if.cardReq) : int'(g_dut[1].u_if.cardReq);
  endfunction
  function automatic int rd_of(input int sel);
    return (sel == 0) ? g_dut[0].rd : g_dut[1].rd;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic wait_mask(input int sel, input bit [15:0] mask, input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (mask[st(sel)]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: timeout, state %0d", name, st(sel));
    end
  endtask

  task automatic pulse(input int sel, input bit d, input bit h, input bit s);
    deal_s[sel]  = d;
    hit_s[sel]   = h;
    stand_s[sel] = s;
    @(negedge clk);
    deal_s[sel]  = 1'b0;
    hit_s[sel]   = 1'b0;
    stand_s[sel] = 1'b0;
  endtask

  // Writes cards (first card in the top nibble) at the instance's read pointer.
  task automatic load(input int sel, input logic [31:0] cards, input int n, output int base);
    base = rd_of(sel);
    for (int i = 0; i < n; i++) deck[sel][(base + i) % DECK_N] = int'(cards[31-4*i -: 4]);
  endtask

  task automatic start_round(input int sel);
    pulse(sel, 1'b1, 1'b0, 1'b0);
    wait_mask(sel, M_POST_DEAL, 400, "deal_done");
  endtask

  task automatic finish_round(input int sel, input int hits);
    int h;
    h = 0;
    while ((st(sel) == 3) && (h < hits)) begin
      pulse(sel, 1'b0, 1'b1, 1'b0);
      h++;
      for (int i = 0; i < 300; i++) begin
        if (rq(sel) == 0) break;
        @(negedge clk);
      end
    end
    if (st(sel) == 3) pulse(sel, 1'b0, 1'b0, 1'b1);
    wait_mask(sel, M_RESULT, 600, "round_done");
    repeat (2) @(negedge clk);
  endtask

  // Reference model: replays the round from the deck using the game rules directly.
  function automatic int cval(input int c);
    return ((c == 0) || (c > 10)) ? 10 : c;
  endfunction
  function automatic int total(input int hard, input bit ace);
    int h;
    h = (hard > 31) ? 31 : hard;
    return (ace && h <= 11) ? h + 10 : h;
  endfunction

  function automatic void model(input int sel, input int base, input int hits,
                                output int ep, output int ed, output int es, output int en);
    int  p_sum, d_sum, idx, c;
    bit  p_ace, d_ace, lost;
    p_sum = 0; d_sum = 0; p_ace = 0; d_ace = 0; idx = 0; lost = 0;
    for (int k = 0; k < 4; k++) begin
      c = deck[sel][(base + idx) % DECK_N]; idx++;
      if (k % 2 == 0) begin p_sum += cval(c); p_ace |= (c == 1); end
      else            begin d_sum += cval(c); d_ace |= (c == 1); end
    end
    ep = total(p_sum, p_ace);
    ed = total(d_sum, d_ace);
    if (ep == 21) begin
      es = (ed == 21) ? 8 : 6;
      en = idx;
      return;
    end
    for (int k = 0; k < hits; k++) begin
      c = deck[sel][(base + idx) % DECK_N]; idx++;
      p_sum += cval(c); p_ace |= (c == 1);
      ep = total(p_sum, p_ace);
      if (ep > 21) begin lost = 1; break; end
      if (ep == 21) break;
    end
    if (lost) begin
      es = 7;
    end else begin
      while ((ed < STAND) ||
             ((sel == 1) && (ed == STAND) && d_ace && (d_sum <= 11))) begin
        c = deck[sel][(base + idx) % DECK_N]; idx++;
        d_sum += cval(c); d_ace |= (c == 1);
        ed = total(d_sum, d_ace);
      end
      if (ed > 21)      es = 6;
      else if (ep > ed) es = 6;
      else if (ep < ed) es = 7;
      else              es = 8;
    end
    en = idx;
  endfunction

  function automatic int rand_card();
    int v;
    if ($urandom % 8 == 0) begin
      v = int'($urandom % 6);
      return (v == 0) ? 0 : 10 + v;
    end
    return 1 + int'($urandom % 10);
  endfunction

  typedef struct packed {
    logic        sel;
    logic [31:0] cards;
    logic [3:0]  n;
    logic [3:0]  hits;
    logic [3:0]  delay;
    logic [4:0]  ep;
    logic [4:0]  ed;
    logic [3:0]  es;
    logic [3:0]  en;
  } vec_t;

  initial begin
    vec_t vecs[13];
    int base, ep, ed, es, en, sel, hits, n0;

    n_tests = 0;
    n_fail  = 0;
    for (int s = 0; s < 2; s++) begin
      deal_s[s] = 0; hit_s[s] = 0; stand_s[s] = 0; delay_s[s] = 0;
    end

    //           sel  cards         n  hits dly  ep  ed  es en
    vecs[0]  = '{1'b0, 32'h1AA10000, 4'd4, 4'd0, 4'd1, 5'd21, 5'd21, 4'd8, 4'd4};
    vecs[1]  = '{1'b0, 32'h7958A000, 4'd5, 4'd1, 4'd0, 5'd22, 5'd17, 4'd7, 4'd5};
    vecs[2]  = '{1'b0, 32'hA284A500, 4'd6, 4'd0, 4'd2, 5'd18, 5'd21, 4'd7, 4'd6};
    vecs[3]  = '{1'b0, 32'hA186A000, 4'd5, 4'd0, 4'd1, 5'd18, 5'd17, 4'd6, 4'd4};
    vecs[4]  = '{1'b1, 32'hA186A000, 4'd5, 4'd0, 4'd1, 5'd18, 5'd17, 4'd6, 4'd5};
    vecs[5]  = '{1'b0, 32'h19A70000, 4'd4, 4'd0, 4'd0, 5'd21, 5'd16, 4'd6, 4'd4};
    vecs[6]  = '{1'b0, 32'hAAA6A000, 4'd5, 4'd0, 4'd3, 5'd20, 5'd26, 4'd6, 4'd5};
    vecs[7]  = '{1'b0, 32'h5A67A000, 4'd5, 4'd2, 4'd1, 5'd21, 5'd17, 4'd6, 4'd5};
    vecs[8]  = '{1'b0, 32'hAA880000, 4'd4, 4'd0, 4'd0, 5'd18, 5'd18, 4'd8, 4'd4};
    vecs[9]  = '{1'b0, 32'h0D980000, 4'd4, 4'd0, 4'd2, 5'd19, 5'd18, 4'd6, 4'd4};
    vecs[10] = '{1'b0, 32'h15169A00, 4'd6, 4'd1, 4'd1, 5'd21, 5'd21, 4'd8, 4'd6};
    vecs[11] = '{1'b1, 32'hA1A65600, 4'd6, 4'd0, 4'd0, 5'd20, 5'd18, 4'd6, 4'd6};
    vecs[12] = '{1'b0, 32'h9195A300, 4'd6, 4'd0, 4'd2, 5'd18, 5'd19, 4'd7, 4'd6};

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_state", st(0), 0);
    check("rst_req", rq(0), 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_state", st(0), 0);
    check("idle_player", ph(0), 0);
    check("idle_dealer", dh(0), 0);
    check("idle_state_hs17", st(1), 0);

    // Dealt hand shown mid-round, then dealer 15 draws 2 and stops at 17.
    delay_s[0] = 2;
    load(0, 32'hA7982000, 5, base);
    start_round(0);
    check("deal_player", ph(0), 19);
    check("deal_dealer", dh(0), 15);
    check("deal_state", st(0), 3);
    check("deal_cards", rd_of(0) - base, 4);
    finish_round(0, 0);
    check("h1_state", st(0), 6);
    check("h1_dealer", dh(0), 17);

    for (int i = 0; i < 13; i++) begin
      sel = int'(vecs[i].sel);
      delay_s[sel] = int'(vecs[i].delay);
      load(sel, vecs[i].cards, int'(vecs[i].n), base);
      start_round(sel);
      finish_round(sel, int'(vecs[i].hits));
      check($sformatf("vec%0d_player", i), ph(sel), int'(vecs[i].ep));
      check($sformatf("vec%0d_dealer", i), dh(sel), int'(vecs[i].ed));
      check($sformatf("vec%0d_state", i), st(sel), int'(vecs[i].es));
      check($sformatf("vec%0d_cards", i), rd_of(sel) - base, int'(vecs[i].en));
    end

    // hit and stand together: stand wins, no player card drawn.
    delay_s[0] = 1;
    load(0, 32'hAA890000, 4, base);
    start_round(0);
    pulse(0, 1'b0, 1'b1, 1'b1);
    check("hs_state", st(0), 4);
    check("hs_req", rq(0), 0);
    wait_mask(0, M_RESULT, 100, "hs_done");
    repeat (2) @(negedge clk);
    check("hs_result", st(0), 7);
    check("hs_player", ph(0), 18);
    check("hs_cards", rd_of(0) - base, 4);

    // Buttons in a result state must not request cards; totals hold.
    n0 = rd_of(0);
    pulse(0, 1'b0, 1'b1, 1'b0);
    pulse(0, 1'b0, 1'b0, 1'b1);
    repeat (6) @(negedge clk);
    check("res_cards", rd_of(0) - n0, 0);
    check("res_hold_state", st(0), 7);
    check("res_hold_dealer", dh(0), 19);

    // Randomised rounds against the model.
    for (int r = 0; r < 40; r++) begin
      logic [31:0] cards;
      sel  = int'($urandom % 2);
      hits = int'($urandom % 4);
      delay_s[sel] = int'($urandom % 4);
      for (int k = 0; k < 8; k++) cards[31-4*k -: 4] = 4'(rand_card());
      load(sel, cards, 8, base);
      for (int k = 8; k < 14; k++) deck[sel][(base + k) % DECK_N] = rand_card();
      model(sel, base, hits, ep, ed, es, en);
      start_round(sel);
      finish_round(sel, hits);
      check($sformatf("rnd%0d_player", r), ph(sel), ep);
      check($sformatf("rnd%0d_dealer", r), dh(sel), ed);
      check($sformatf("rnd%0d_state", r), st(sel), es);
      check($sformatf("rnd%0d_cards", r), rd_of(sel) - base, en);
    end

    // Reset while a hit card is outstanding clears everything immediately.
    delay_s[0] = 20;
    load(0, 32'h7958A000, 5, base);
    start_round(0);
    pulse(0, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("mid_req_high", rq(0), 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_req", rq(0), 0);
    check("mid_rst_state", st(0), 0);
    check("mid_rst_player", ph(0), 0);
    check("mid_rst_dealer", dh(0), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_req", rq(0), 0);

    check("req_drop_dut0", g_dut[0].viol, 0);
    check("req_drop_dut1", g_dut[1].viol, 0);
    check("req_in_result_dut0", g_dut[0].req_res, 0);
    check("req_in_result_dut1", g_dut[1].req_res, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/game_controller.md
Name: game_controller

Overview:
- Blackjack round sequencer directly upstream of the seven-segment output stage; produces the `playerHand`, `dealerHand` and `gameState` values that stage displays.
- Pulls cards from the card source through a req/valid handshake and accepts debounced single-cycle `deal`/`hit`/`stand` pulses from the button stage.
- Keeps both hand totals with soft-ace handling, runs the dealer draw rule and resolves win/lose/tie.

Parameters:
- DEALER_STAND, 17: dealer stops drawing once its total is at or above this value.
- HIT_SOFT17, 0: when 1, the dealer also draws on a soft total equal to DEALER_STAND.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- deal  input  1  one-cycle pulse: start a new round.
- hit  input  1  one-cycle pulse: player requests a card.
- stand  input  1  one-cycle pulse: player ends turn.
- cardValid  input  1  card source has a card on cardValue.
- cardValue  input  4  1 = ace, 2..10 = pip or face value.
- cardReq  output  1  request for the next card.
- playerHand  output  5  player best total, unsigned.
- dealerHand  output  5  dealer best total, unsigned.
- gameState  output  4  current FSM state encoding, consumed by the display stage.

Behaviour:
- Reset (async, asserted): state S_RESET; playerHand, dealerHand = 0; cardReq = 0; internal hard sums, ace flags and deal counter cleared.
- Encodings, fixed:
  - S_RESET = 0, S_DEAL_PLAYER = 1, S_DEAL_DEALER = 2, S_PLAYER_TURN = 3, S_DEALER_TURN = 4, S_COMPARE = 5.
  - S_RESULT_WIN = 6, S_RESULT_LOSE = 7, S_RESULT_TIE = 8.
  - Values 9–15 are unused and return to S_RESET.
- Card handshake:
  - cardReq is registered. It rises the cycle after a draw is needed and is held until a cycle with cardReq && cardValid.
  - That card is consumed on that edge; cardReq is 0 the next cycle.
  - At most one card is consumed per handshake; cardValid while cardReq = 0 is ignored.
  - cardValue of 0 or 11–15 is treated as 10.
- Hand arithmetic:
  - Per hand: 5-bit hard sum (ace = 1, saturating at 31) plus an ace-seen flag.
  - Best total = hard + 10 if ace-seen and hard ≤ 11, else hard.
  - A total is soft when that +10 was applied.
  - Outputs are registered and updated on the edge that consumes the card.
- S_RESET: deal → clear hands, deal counter = 0, go to S_DEAL_PLAYER.
- Initial deal: alternates S_DEAL_PLAYER / S_DEAL_DEALER for 4 cards in the order P, D, P, D; the counter increments per consumed card.
- After the 4th card:
  - Player 21 and dealer 21 → S_RESULT_TIE.
  - Player 21 only → S_RESULT_WIN.
  - Otherwise → S_PLAYER_TURN.
- S_PLAYER_TURN, with no card pending:
  - stand → S_DEALER_TURN.
  - hit → draw one card. After it is consumed: total > 21 → S_RESULT_LOSE; total = 21 → S_DEALER_TURN; else stay.
  - hit and stand in the same cycle: stand wins.
  - hit or stand while cardReq = 1: ignored.
- S_DEALER_TURN:
  - Draws while total < DEALER_STAND, or while HIT_SOFT17 = 1 and total = DEALER_STAND and soft.
  - Total > 21 → S_RESULT_WIN. Otherwise stop → S_COMPARE.
- S_COMPARE (one cycle): player > dealer → WIN; player < dealer → LOSE; equal → TIE.
- Result states:
  - Hold the state and both totals until deal.
  - deal → clear hands and go to S_DEAL_PLAYER (same as from S_RESET).
- deal pulses outside S_RESET and the result states are ignored; a round cannot be restarted mid-play.
- Reset asserted mid-handshake drops cardReq immediately (async) and discards any pending card.

Test Plan:
- Reset, then deal; source returns 10, 7, 9, 8 each with a 2-cycle valid delay → playerHand = 19, dealerHand = 15, gameState = 3; cardReq deasserts the cycle after each accept.
- Deal cards 1, 10, 10, 1 → player 21 and dealer 21 → gameState = 8, with no further cardReq.
- Player at 12 (7, 5): hit, card 10 → playerHand = 22, gameState = 7; later hit pulses produce no cardReq.
- Player stands at 18; dealer holds 6 and draws 10 (total 16) then 5 → dealerHand = 21, then S_COMPARE → gameState = 7.
- HIT_SOFT17 = 1: dealer holds 1, 6 (soft 17) → draws; card 10 → hard 17 and stops. With HIT_SOFT17 = 0, the dealer stops at soft 17.
- hit and stand in the same cycle → S_DEALER_TURN with no player card drawn. Reset asserted while cardReq = 1 → cardReq = 0, gameState = 0, both hands = 0 in the same cycle.
